// File: rtl/mult_arbiter_if.sv
// Requester and multiplier bus around mult_arbiter.
// slave: arbiter view; master: requesters + multiplier view.
interface mult_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req;
  logic [64*NUM_REQ-1:0] req_mcand;
  logic [64*NUM_REQ-1:0] req_mplier;
  logic [NUM_REQ-1:0]    gnt;
  logic [NUM_REQ-1:0]    resp_valid;
  logic [63:0]           resp_product;
  logic                  m_start;
  logic [63:0]           m_mcand;
  logic [63:0]           m_mplier;
  logic [63:0]           m_product;
  logic                  m_done;

  modport slave (
    input  req, req_mcand, req_mplier,
    input  m_product, m_done,
    output gnt, resp_valid, resp_product,
    output m_start, m_mcand, m_mplier
  );

  modport master (
    output req, req_mcand, req_mplier,
    output m_product, m_done,
    input  gnt, resp_valid, resp_product,
    input  m_start, m_mcand, m_mplier
  );
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin issue of NUM_REQ requesters onto one pipelined multiplier.
// Ports: clock, reset (async low), pause, bus (slave), inflight, err.
module mult_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int MULT_LAT = 2,
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CW  = $clog2(MULT_LAT + 2)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          pause,
  mult_arbiter_if.slave bus,
  output logic [CW-1:0] inflight,
  output logic          err
);

  typedef struct packed {
    logic           valid;
    logic [IDW-1:0] id;
  } tag_t;

  tag_t                 issue;
  tag_t [MULT_LAT-1:0]  pipe;
  tag_t                 tail;
  logic [IDW-1:0]       rr_ptr;
  logic [IDW-1:0]       win;
  logic                 hit;
  logic [NUM_REQ-1:0]   cand;
  logic [NUM_REQ-1:0]   rv;
  logic [CW-1:0]        cnt_nxt;
  logic [63:0]          mc_arr [NUM_REQ];
  logic [63:0]          ml_arr [NUM_REQ];
  int                   idx;

  assign tail = pipe[MULT_LAT-1];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_ops
    assign mc_arr[g] = bus.req_mcand[64*g +: 64];
    assign ml_arr[g] = bus.req_mplier[64*g +: 64];
  end

  // Reset is folded in so gnt reads zero while reset is held.
  always_comb begin
    cand = bus.req & {NUM_REQ{~pause & reset}};
    hit  = 1'b0;
    win  = '0;
    idx  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!hit && cand[idx[IDW-1:0]]) begin
        hit = 1'b1;
        win = idx[IDW-1:0];
      end
    end
  end

  assign bus.gnt = hit
    ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << win)
    : '0;

  always_comb begin
    rv = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rv[i] = bus.m_done & tail.valid &
              (tail.id == IDW'(i));
    end
  end

  assign bus.resp_valid   = rv;
  assign bus.resp_product = bus.m_product;

  // Occupancy as it will stand after this edge.
  always_comb begin
    cnt_nxt = CW'(hit) + CW'(issue.valid);
    for (int j = 0; j < MULT_LAT - 1; j++) begin
      cnt_nxt = cnt_nxt + CW'(pipe[j].valid);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr       <= '0;
      bus.m_start  <= 1'b0;
      bus.m_mcand  <= '0;
      bus.m_mplier <= '0;
      issue        <= '0;
      pipe         <= '0;
      inflight     <= '0;
      err          <= 1'b0;
    end else begin
      bus.m_start <= hit;
      issue.valid <= hit;
      issue.id    <= win;
      if (hit) begin
        bus.m_mcand  <= mc_arr[win];
        bus.m_mplier <= ml_arr[win];
        rr_ptr <= (win == IDW'(NUM_REQ - 1))
          ? '0 : win + IDW'(1);
      end
      pipe[0] <= issue;
      for (int j = 1; j < MULT_LAT; j++) begin
        pipe[j] <= pipe[j-1];
      end
      inflight <= cnt_nxt;
      if (bus.m_done != tail.valid) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// Randomized and directed checks of mult_arbiter.
// Includes a behavioural multiplier and a queue-based reference.
module tb_mult_arbiter;
  localparam int N = 4;
  localparam int L = 2;

  logic       clk;
  logic       rst_n;
  logic       pause;
  logic       force_done;
  logic [1:0] inflight;
  logic       err;

  mult_arbiter_if #(.NUM_REQ(N)) bus ();

  mult_arbiter #(.NUM_REQ(N), .MULT_LAT(L)) dut (
    .clock    (clk),
    .reset    (rst_n),
    .pause    (pause),
    .bus      (bus),
    .inflight (inflight),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        st [L];
  logic [63:0] pa [L];
  logic [63:0] pb [L];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < L; j++) begin
        st[j] <= 1'b0;
        pa[j] <= '0;
        pb[j] <= '0;
      end
    end else begin
      st[0] <= bus.m_start;
      pa[0] <= bus.m_mcand;
      pb[0] <= bus.m_mplier;
      for (int j = 1; j < L; j++) begin
        st[j] <= st[j-1];
        pa[j] <= pa[j-1];
        pb[j] <= pb[j-1];
      end
    end
  end

  assign bus.m_done    = st[L-1] | force_done;
  assign bus.m_product = pa[L-1] * pb[L-1];

  typedef struct {
    int          due;
    int          id;
    logic [63:0] prod;
  } exp_t;

  int          cyc;
  int          n_cmp;
  int          n_bad;
  int          mp;
  exp_t        exp_q [$];
  int          gcyc_q [$];
  logic [63:0] mc [N];
  logic [63:0] ml [N];

  function automatic logic [63:0] rnd64();
    if ($urandom % 4 == 0) return 64'($urandom % 100);
    return {$urandom, $urandom};
  endfunction

  task automatic apply();
    bus.req_mcand  = {mc[3], mc[2], mc[1], mc[0]};
    bus.req_mplier = {ml[3], ml[2], ml[1], ml[0]};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic model_reset();
    exp_q.delete();
    gcyc_q.delete();
    mp = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req = '0;
    pause = 1'b0;
    model_reset();
    step();
    rst_n = 1'b1;
  endtask

  function automatic logic [N-1:0] ref_gnt(
    input logic [N-1:0] r,
    input logic         p,
    input logic         rs
  );
    logic [1:0] i;
    if (p || !rs) return '0;
    for (int k = 0; k < N; k++) begin
      i = 2'((mp + k) % N);
      if (r[i]) return 4'(1) << i;
    end
    return '0;
  endfunction

  task automatic commit(input logic [N-1:0] g);
    exp_t       e;
    logic [1:0] id;
    if (g == '0) return;
    id = 0;
    for (int k = 0; k < N; k++) begin
      if (g == (4'(1) << k)) id = 2'(k);
    end
    e.due  = cyc + 1 + L;
    e.id   = int'(id);
    e.prod = mc[id] * ml[id];
    exp_q.push_back(e);
    gcyc_q.push_back(cyc);
    mp = (int'(id) + 1) % N;
    mc[id] = rnd64();
    ml[id] = rnd64();
  endtask

  task automatic model_resp(
    output logic [N-1:0] rv,
    output logic [63:0]  pr
  );
    rv = '0;
    pr = '0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      rv = 4'(1) << exp_q[0].id;
      pr = exp_q[0].prod;
      exp_q.delete(0);
    end
  endtask

  function automatic int exp_inflight();
    int c = 0;
    foreach (gcyc_q[k]) begin
      if (gcyc_q[k] >= cyc - 1 - L && gcyc_q[k] <= cyc - 1) c++;
    end
    return c;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req = 4'b1111;
    step();
    n_cmp++;
    if (bus.gnt !== 4'b0) begin
      n_bad++;
      $display("FAIL rst_gnt got=%b exp=0", bus.gnt);
    end
    n_cmp++;
    if (bus.m_start !== 1'b0 || bus.m_mcand !== 64'd0) begin
      n_bad++;
      $display("FAIL rst_issue got=%b/%0d exp=0/0",
               bus.m_start, bus.m_mcand);
    end
    n_cmp++;
    if (inflight !== 2'd0 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_state got=%0d/%b exp=0/0", inflight, err);
    end
    n_cmp++;
    if (bus.resp_valid !== 4'b0) begin
      n_bad++;
      $display("FAIL rst_resp got=%b exp=0", bus.resp_valid);
    end
    bus.req = '0;
    rst_n = 1'b1;
    model_reset();
    step();
  endtask

  task automatic test_single();
    do_reset();
    mc[0] = 64'd7;
    ml[0] = 64'd6;
    apply();
    bus.req = 4'b0001;
    #1;
    n_cmp++;
    if (bus.gnt !== 4'b0001) begin
      n_bad++;
      $display("FAIL single_gnt got=%b exp=0001", bus.gnt);
    end
    step();
    bus.req = '0;
    n_cmp++;
    if (bus.m_start !== 1'b1 || bus.m_mcand !== 64'd7 ||
        bus.m_mplier !== 64'd6) begin
      n_bad++;
      $display("FAIL single_issue got=%b/%0d/%0d exp=1/7/6",
               bus.m_start, bus.m_mcand, bus.m_mplier);
    end
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) step();
      n_cmp++;
      if (inflight !== ((c == 4) ? 2'd0 : 2'd1)) begin
        n_bad++;
        $display("FAIL single_inflight c=%0d got=%0d", c, inflight);
      end
      n_cmp++;
      if (bus.resp_valid !== ((c == 3) ? 4'b0001 : 4'b0)) begin
        n_bad++;
        $display("FAIL single_resp c=%0d got=%b", c, bus.resp_valid);
      end
      if (c == 3) begin
        n_cmp++;
        if (bus.resp_product !== 64'd42) begin
          n_bad++;
          $display("FAIL single_prod got=%0d exp=42",
                   bus.resp_product);
        end
      end
    end
    step();
  endtask

  task automatic test_skip_wrap();
    logic [N-1:0] seq_r [3];
    logic [N-1:0] seq_g [3];
    seq_r[0] = 4'b0100; seq_g[0] = 4'b0100;
    seq_r[1] = 4'b0101; seq_g[1] = 4'b0001;
    seq_r[2] = 4'b0100; seq_g[2] = 4'b0100;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      bus.req = seq_r[c];
      #1;
      n_cmp++;
      if (bus.gnt !== seq_g[c]) begin
        n_bad++;
        $display("FAIL skip_gnt c=%0d got=%b exp=%b",
                 c, bus.gnt, seq_g[c]);
      end
      step();
    end
    bus.req = '0;
    n_cmp++;
    if (bus.resp_valid !== 4'b0100) begin
      n_bad++;
      $display("FAIL skip_resp got=%b exp=0100", bus.resp_valid);
    end
    step();
    step();
    step();
  endtask

  task automatic test_pause();
    logic [63:0] p1;
    do_reset();
    mc[1] = rnd64();
    ml[1] = rnd64();
    p1 = mc[1] * ml[1];
    apply();
    bus.req = 4'b0010;
    #1;
    n_cmp++;
    if (bus.gnt !== 4'b0010) begin
      n_bad++;
      $display("FAIL pause_gnt0 got=%b exp=0010", bus.gnt);
    end
    step();
    mc[1] = rnd64();
    apply();
    for (int c = 1; c <= 4; c++) begin
      pause = 1'b1;
      #1;
      n_cmp++;
      if (bus.gnt !== 4'b0) begin
        n_bad++;
        $display("FAIL pause_gnt c=%0d got=%b exp=0", c, bus.gnt);
      end
      n_cmp++;
      if (bus.resp_valid !== ((c == 3) ? 4'b0010 : 4'b0)) begin
        n_bad++;
        $display("FAIL pause_resp c=%0d got=%b", c, bus.resp_valid);
      end
      if (c == 3) begin
        n_cmp++;
        if (bus.resp_product !== p1) begin
          n_bad++;
          $display("FAIL pause_prod got=%h exp=%h",
                   bus.resp_product, p1);
        end
      end
      step();
    end
    pause = 1'b0;
    #1;
    n_cmp++;
    if (bus.gnt !== 4'b0010) begin
      n_bad++;
      $display("FAIL pause_resume got=%b exp=0010", bus.gnt);
    end
    step();
    bus.req = '0;
    for (int c = 0; c < 4; c++) step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.req = 4'b0011;
    step();
    bus.req = 4'b0010;
    step();
    bus.req = 4'b1111;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.m_start !== 1'b0 || inflight !== 2'd0 ||
        err !== 1'b0 || bus.gnt !== 4'b0) begin
      n_bad++;
      $display("FAIL mid_rst got=%b/%0d/%b/%b exp=0/0/0/0",
               bus.m_start, inflight, err, bus.gnt);
    end
    step();
    rst_n = 1'b1;
    bus.req = '0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++;
      if (bus.resp_valid !== 4'b0) begin
        n_bad++;
        $display("FAIL mid_stale c=%0d got=%b exp=0",
                 c, bus.resp_valid);
      end
      step();
    end
    bus.req = 4'b1111;
    #1;
    n_cmp++;
    if (bus.gnt !== 4'b0001) begin
      n_bad++;
      $display("FAIL mid_next got=%b exp=0001", bus.gnt);
    end
    step();
    bus.req = '0;
    for (int c = 0; c < 4; c++) step();
  endtask

  task automatic test_round_robin();
    logic [N-1:0] eg, er;
    logic [63:0]  ep;
    do_reset();
    for (int t = 0; t < 8 + L + 2; t++) begin
      bus.req = (t < 8) ? 4'b1111 : 4'b0;
      apply();
      #1;
      eg = ref_gnt(bus.req, pause, rst_n);
      model_resp(er, ep);
      n_cmp++;
      if (bus.gnt !== eg) begin
        n_bad++;
        $display("FAIL rr_gnt t=%0d got=%b exp=%b", t, bus.gnt, eg);
      end
      n_cmp++;
      if (bus.resp_valid !== er) begin
        n_bad++;
        $display("FAIL rr_resp t=%0d got=%b exp=%b",
                 t, bus.resp_valid, er);
      end
      if (er != '0) begin
        n_cmp++;
        if (bus.resp_product !== ep) begin
          n_bad++;
          $display("FAIL rr_prod t=%0d got=%h exp=%h",
                   t, bus.resp_product, ep);
        end
      end
      n_cmp++;
      if (inflight !== 2'(exp_inflight())) begin
        n_bad++;
        $display("FAIL rr_inflight t=%0d got=%0d exp=%0d",
                 t, inflight, exp_inflight());
      end
      commit(eg);
      step();
    end
  endtask

  task automatic test_random();
    logic [N-1:0] r, eg, er;
    logic [63:0]  ep;
    do_reset();
    r = '0;
    for (int t = 0; t < 300 + L + 2; t++) begin
      if (t < 300) begin
        r = r | 4'($urandom);
        pause = ($urandom % 5) == 0;
      end else begin
        r = '0;
        pause = 1'b0;
      end
      bus.req = r;
      apply();
      #1;
      eg = ref_gnt(r, pause, rst_n);
      model_resp(er, ep);
      n_cmp++;
      if (bus.gnt !== eg) begin
        n_bad++;
        $display("FAIL rnd_gnt t=%0d got=%b exp=%b", t, bus.gnt, eg);
      end
      n_cmp++;
      if (bus.resp_valid !== er) begin
        n_bad++;
        $display("FAIL rnd_resp t=%0d got=%b exp=%b",
                 t, bus.resp_valid, er);
      end
      if (er != '0) begin
        n_cmp++;
        if (bus.resp_product !== ep) begin
          n_bad++;
          $display("FAIL rnd_prod t=%0d got=%h exp=%h",
                   t, bus.resp_product, ep);
        end
      end
      n_cmp++;
      if (inflight !== 2'(exp_inflight()) || err !== 1'b0) begin
        n_bad++;
        $display("FAIL rnd_state t=%0d got=%0d/%b exp=%0d/0",
                 t, inflight, err, exp_inflight());
      end
      commit(eg);
      r = r & ~eg;
      step();
    end
  endtask

  task automatic test_protocol_error();
    do_reset();
    step();
    force_done = 1'b1;
    #1;
    n_cmp++;
    if (bus.resp_valid !== 4'b0 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL perr_now got=%b/%b exp=0/0",
               bus.resp_valid, err);
    end
    step();
    force_done = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_cmp++;
      if (err !== 1'b1) begin
        n_bad++;
        $display("FAIL perr_sticky c=%0d got=%b exp=1", c, err);
      end
      step();
    end
    do_reset();
    n_cmp++;
    if (err !== 1'b0) begin
      n_bad++;
      $display("FAIL perr_clear got=%b exp=0", err);
    end
  endtask

  initial begin
    cyc = 0;
    n_cmp = 0;
    n_bad = 0;
    mp = 0;
    rst_n = 1'b0;
    pause = 1'b0;
    force_done = 1'b0;
    bus.req = '0;
    for (int i = 0; i < N; i++) begin
      mc[i] = rnd64();
      ml[i] = rnd64();
    end
    apply();
    test_reset();
    test_single();
    test_round_robin();
    test_skip_wrap();
    test_pause();
    test_reset_mid();
    test_random();
    test_protocol_error();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
